// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared states, default framing constants and payload byte slicing helper
package uart_frame_pkg;
  typedef enum logic [1:0] {IDLE, GOT_HEAD, PAYLOAD, CHECK} state_t;
  localparam logic [7:0] DEF_HEAD = 8'hAA;
  localparam logic [7:0] DEF_ID = 8'h02;
  localparam logic [7:0] DEF_CHK_INIT = 8'hFF;
  function automatic int byte_lsb(input int k);
    return 8 * k;
  endfunction
endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: counts idle clocks between kicks and pulses expire after TIMEOUT_CYC silent cycles
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk50M,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign expire = enable && !kick && (cnt == W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk50M) begin
    if (rst || !enable || kick || expire) cnt <= '0;
    else cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: validates HEAD/ID/payload/XOR-check frames from uart_rx and publishes the payload
import uart_frame_pkg::*;
module uart_frame_parser #(
  parameter logic [7:0] HEAD_BYTE = DEF_HEAD,
  parameter logic [7:0] ID_BYTE = DEF_ID,
  parameter int PAYLOAD_BYTES = 19,
  parameter logic [7:0] CHK_INIT = DEF_CHK_INIT,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W = 16
) (
  input  logic                       clk50M,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       flag_in,
  output logic [8*PAYLOAD_BYTES-1:0] payload,
  output logic [7:0]                 frame_id,
  output logic                       flag_out,
  output logic                       err_chk,
  output logic                       err_id,
  output logic                       err_timeout,
  output logic [CNT_W-1:0]           good_cnt,
  output logic [CNT_W-1:0]           bad_cnt,
  output logic                       busy
);
  localparam int IDX_W = PAYLOAD_BYTES > 1 ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PAYLOAD_BYTES - 1);
  state_t state;
  logic [7:0] chk;
  logic [IDX_W-1:0] idx;
  logic [8*PAYLOAD_BYTES-1:0] shadow;
  logic expire;
  assign busy = state != IDLE;
  uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk50M(clk50M),
    .rst(rst),
    .enable(busy),
    .kick(flag_in),
    .expire(expire)
  );
  // expire is never asserted together with flag_in, so the byte always wins the race
  always_ff @(posedge clk50M) begin
    if (rst) begin
      state <= IDLE;
      chk <= CHK_INIT;
      idx <= '0;
      shadow <= '0;
      payload <= '0;
      frame_id <= '0;
      flag_out <= 1'b0;
      err_chk <= 1'b0;
      err_id <= 1'b0;
      err_timeout <= 1'b0;
      good_cnt <= '0;
      bad_cnt <= '0;
    end else begin
      flag_out <= 1'b0;
      err_chk <= 1'b0;
      err_id <= 1'b0;
      err_timeout <= 1'b0;
      if (expire) begin
        err_timeout <= 1'b1;
        state <= IDLE;
        if (~&bad_cnt) bad_cnt <= bad_cnt + CNT_W'(1);
      end else if (flag_in) begin
        case (state)
          IDLE: begin
            if (rx_data == HEAD_BYTE) begin
              state <= GOT_HEAD;
              chk <= CHK_INIT;
            end
          end
          GOT_HEAD: begin
            if (rx_data == ID_BYTE) begin
              state <= PAYLOAD;
              chk <= CHK_INIT ^ rx_data;
              idx <= '0;
            end else begin
              err_id <= 1'b1;
              if (~&bad_cnt) bad_cnt <= bad_cnt + CNT_W'(1);
              state <= (rx_data == HEAD_BYTE) ? GOT_HEAD : IDLE;
            end
          end
          PAYLOAD: begin
            shadow[byte_lsb(int'(idx)) +: 8] <= rx_data;
            chk <= chk ^ rx_data;
            idx <= idx + IDX_W'(1);
            if (idx == LAST) state <= CHECK;
          end
          CHECK: begin
            if (rx_data == chk) begin
              payload <= shadow;
              frame_id <= ID_BYTE;
              flag_out <= 1'b1;
              if (~&good_cnt) good_cnt <= good_cnt + CNT_W'(1);
            end else begin
              err_chk <= 1'b1;
              if (~&bad_cnt) bad_cnt <= bad_cnt + CNT_W'(1);
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed table-driven checks on a 2-byte and a default 19-byte payload parser
module tb_uart_frame_parser;
  logic clk50M = 1'b0;
  always #5 clk50M = ~clk50M;
  logic rst_a, rst_b, flag_a, flag_b;
  logic [7:0] rx_a, rx_b, id_a, id_b;
  logic [15:0] pay_a;
  logic [151:0] pay_b;
  logic fo_a, ec_a, ei_a, et_a, busy_a, fo_b, ec_b, ei_b, et_b, busy_b;
  logic [15:0] good_a, bad_a, good_b, bad_b;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] b;
    logic fo, ec, ei;
    logic [15:0] pay, good, bad;
    logic busy;
  } vec_t;
  vec_t v[24];

  uart_frame_parser #(.PAYLOAD_BYTES(2), .TIMEOUT_CYC(20)) dut_a (
    .clk50M(clk50M), .rst(rst_a), .rx_data(rx_a), .flag_in(flag_a),
    .payload(pay_a), .frame_id(id_a), .flag_out(fo_a), .err_chk(ec_a),
    .err_id(ei_a), .err_timeout(et_a), .good_cnt(good_a), .bad_cnt(bad_a), .busy(busy_a)
  );
  uart_frame_parser #(.TIMEOUT_CYC(20)) dut_b (
    .clk50M(clk50M), .rst(rst_b), .rx_data(rx_b), .flag_in(flag_b),
    .payload(pay_b), .frame_id(id_b), .flag_out(fo_b), .err_chk(ec_b),
    .err_id(ei_b), .err_timeout(et_b), .good_cnt(good_b), .bad_cnt(bad_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick_a(input logic [7:0] b, input logic f);
    rx_a = b;
    flag_a = f;
    @(negedge clk50M);
  endtask
  task automatic tick_b(input logic [7:0] b, input logic f);
    rx_b = b;
    flag_b = f;
    @(negedge clk50M);
  endtask

  initial begin
    int n;
    v[0]  = '{8'hAA, 0, 0, 0, 16'h0000, 0, 0, 1};
    v[1]  = '{8'h02, 0, 0, 0, 16'h0000, 0, 0, 1};
    v[2]  = '{8'h34, 0, 0, 0, 16'h0000, 0, 0, 1};
    v[3]  = '{8'h12, 0, 0, 0, 16'h0000, 0, 0, 1};
    v[4]  = '{8'hDB, 1, 0, 0, 16'h1234, 1, 0, 0};
    v[5]  = '{8'h11, 0, 0, 0, 16'h1234, 1, 0, 0};
    v[6]  = '{8'hAA, 0, 0, 0, 16'h1234, 1, 0, 1};
    v[7]  = '{8'h02, 0, 0, 0, 16'h1234, 1, 0, 1};
    v[8]  = '{8'h34, 0, 0, 0, 16'h1234, 1, 0, 1};
    v[9]  = '{8'h12, 0, 0, 0, 16'h1234, 1, 0, 1};
    v[10] = '{8'hDA, 0, 1, 0, 16'h1234, 1, 1, 0};
    v[11] = '{8'hAA, 0, 0, 0, 16'h1234, 1, 1, 1};
    v[12] = '{8'hAA, 0, 0, 1, 16'h1234, 1, 2, 1};
    v[13] = '{8'h02, 0, 0, 0, 16'h1234, 1, 2, 1};
    v[14] = '{8'h34, 0, 0, 0, 16'h1234, 1, 2, 1};
    v[15] = '{8'h12, 0, 0, 0, 16'h1234, 1, 2, 1};
    v[16] = '{8'hDB, 1, 0, 0, 16'h1234, 2, 2, 0};
    v[17] = '{8'hAA, 0, 0, 0, 16'h1234, 2, 2, 1};
    v[18] = '{8'h07, 0, 0, 1, 16'h1234, 2, 3, 0};
    v[19] = '{8'hAA, 0, 0, 0, 16'h1234, 2, 3, 1};
    v[20] = '{8'h02, 0, 0, 0, 16'h1234, 2, 3, 1};
    v[21] = '{8'hAA, 0, 0, 0, 16'h1234, 2, 3, 1};
    v[22] = '{8'h55, 0, 0, 0, 16'h1234, 2, 3, 1};
    v[23] = '{8'h02, 1, 0, 0, 16'h55AA, 3, 3, 0};
    rst_a = 1'b1;
    rst_b = 1'b1;
    rx_b = 8'h00;
    flag_b = 1'b0;
    @(negedge clk50M);
    tick_a(8'h00, 1'b0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    check("reset_a", {fo_a, ec_a, ei_a, et_a, busy_a, pay_a, id_a, good_a, bad_a}, '0);
    check("reset_b", {fo_b, ec_b, ei_b, et_b, busy_b, pay_b, id_b, good_b, bad_b}, '0);
    for (int i = 0; i < 24; i++) begin
      tick_a(v[i].b, 1'b1);
      check($sformatf("vec%0d", i), {et_a, fo_a, ec_a, ei_a, pay_a, good_a, bad_a, busy_a},
            {1'b0, v[i].fo, v[i].ec, v[i].ei, v[i].pay, v[i].good, v[i].bad, v[i].busy});
    end
    check("frame_id_a", id_a, 8'h02);
    // partial frame then silence: exactly one timeout
    tick_a(8'hAA, 1'b1);
    tick_a(8'h02, 1'b1);
    tick_a(8'h34, 1'b1);
    n = 0;
    for (int i = 0; i < 25; i++) begin
      tick_a(8'h00, 1'b0);
      n += int'(et_a);
    end
    check("timeout_pulses", n, 1);
    check("timeout_state", {busy_a, bad_a, good_a}, {1'b0, 16'd4, 16'd3});
    // bytes arriving on the expiry cycle are accepted
    n = 0;
    tick_a(8'hAA, 1'b1);
    for (int i = 0; i < 19; i++) begin
      tick_a(8'h00, 1'b0);
      n += int'(et_a);
    end
    tick_a(8'h02, 1'b1);
    n += int'(et_a);
    for (int i = 0; i < 19; i++) begin
      tick_a(8'h00, 1'b0);
      n += int'(et_a);
    end
    tick_a(8'h34, 1'b1);
    tick_a(8'h12, 1'b1);
    tick_a(8'hDB, 1'b1);
    check("edge_no_timeout", n, 0);
    check("post_timeout_frame", {fo_a, pay_a, good_a, bad_a}, {1'b1, 16'h1234, 16'd4, 16'd4});
    tick_a(8'h00, 1'b0);
    check("flag_out_one_cycle", fo_a, 1'b0);
    // full-size frame, payload 00..12, checksum FF^02^13 = EE
    tick_b(8'hAA, 1'b1);
    tick_b(8'h02, 1'b1);
    for (int i = 0; i < 19; i++) tick_b(8'(i), 1'b1);
    tick_b(8'hEE, 1'b1);
    check("big_flag", {fo_b, ec_b, good_b, id_b}, {1'b1, 1'b0, 16'd1, 8'h02});
    check("big_byte0", pay_b[7:0], 8'h00);
    check("big_byte18", pay_b[151:144], 8'h12);
    check("big_byte9", pay_b[79:72], 8'h09);
    tick_b(8'hAA, 1'b1);
    tick_b(8'h02, 1'b1);
    tick_b(8'h00, 1'b1);
    tick_b(8'h05, 1'b1);
    rst_b = 1'b1;
    tick_b(8'h00, 1'b0);
    rst_b = 1'b0;
    check("midframe_reset", {fo_b, ec_b, ei_b, et_b, busy_b, pay_b, id_b, good_b, bad_b}, '0);
    for (int i = 0; i < 25; i++) tick_b(8'h00, 1'b0);
    check("after_reset_quiet", {fo_b, ec_b, ei_b, et_b, busy_b, good_b, bad_b}, '0);
    // repeated heads in GOT_HEAD each raise err_id: drive bad_cnt to saturation
    tick_b(8'hAA, 1'b1);
    for (int i = 0; i < 65535; i++) tick_b(8'hAA, 1'b1);
    check("bad_at_max", {ei_b, bad_b}, {1'b1, 16'hFFFF});
    tick_b(8'hAA, 1'b1);
    check("bad_saturates", {ei_b, bad_b, busy_b}, {1'b1, 16'hFFFF, 1'b1});
    tick_b(8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
